// File: rtl/iddmm_final_sub.sv
// Final conditional-subtraction stage of the IDDMM Montgomery multiplier: emits {an,A}-M or A word-serially.
// Optional macro IDDMM_SUB_CLEAR_EN adds a zero-clear pass over the A memory before task_end.
module iddmm_final_sub #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              task_req,
    output logic              task_end,
    output logic [K-1:0]      res,
    output logic              res_val,
    output logic              clra_mem,
    output logic              clra_wren,
    output logic [ADDR_W-1:0] clra_addr,
    input  logic [K-1:0]      aj,
    input  logic [K-1:0]      an,
    input  logic [K-1:0]      mj,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_m
);

    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_OUT  = 3'd2,
        S_CLR  = 3'd3,
        S_DONE = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    // Returns {borrow_out, a - m - b}; bit K is set whenever the difference went negative.
    function automatic logic [K:0] sub_borrow(input logic [K-1:0] a, input logic [K-1:0] m,
                                              input logic b);
        sub_borrow = {1'b0, a} - {1'b0, m} - {{K{1'b0}}, b};
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                b_q, b_d;
    logic                sel_q, sel_d;
    logic                res_val_q, res_val_d;
    logic                task_end_q, task_end_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [K-1:0]        hold_q;
    logic [K:0]          diff_s;
    logic [K-1:0]        res_word_s;

    assign diff_s     = sub_borrow(aj, mj, b_q);
    assign res_word_s = sel_q ? diff_s[K-1:0] : aj;

    // Memory read data arrives in the same cycle it is emitted, so res is muxed against a hold register.
    assign res      = res_val_q ? res_word_s : hold_q;
    assign res_val  = res_val_q;
    assign task_end = task_end_q;
    assign addr_a   = addr_q;
    assign addr_m   = addr_q;

    // Next-state, borrow chain and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (task_req) begin
                    state_d = S_CMP;
                    cnt_d   = '0;
                    b_d     = 1'b0;
                    sel_d   = 1'b0;
                end else begin
                    cnt_d = '0;
                end
            end
            S_CMP: begin
                if (cnt_q == LAST) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                    b_d     = 1'b0;
                    sel_d   = (an != '0) || !diff_s[K];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q != '0) begin
                        b_d = diff_s[K];
                    end else begin
                        b_d = 1'b0;
                    end
                end
            end
            S_OUT: begin
                if (cnt_q != '0) begin
                    b_d = diff_s[K];
                end else begin
                    b_d = 1'b0;
                end
                if (cnt_q == LAST) begin
`ifdef IDDMM_SUB_CLEAR_EN
                    state_d = S_CLR;
`else
                    state_d = S_DONE;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef IDDMM_SUB_CLEAR_EN
            S_CLR: begin
                if (cnt_q == (LAST - CNT_W'(1))) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!task_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        res_val_d  = (state_d == S_OUT) && (cnt_d != '0);
        task_end_d = (state_d == S_DONE);
        if (((state_d == S_CMP) || (state_d == S_OUT)) && (cnt_d != LAST)) begin
            addr_d = cnt_d[ADDR_W-1:0];
        end else begin
            addr_d = '0;
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            b_q        <= 1'b0;
            sel_q      <= 1'b0;
            res_val_q  <= 1'b0;
            task_end_q <= 1'b0;
            addr_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            res_val_q  <= res_val_d;
            task_end_q <= task_end_d;
            addr_q     <= addr_d;
            hold_q     <= res;
        end
    end

`ifdef IDDMM_SUB_CLEAR_EN
    logic              clr_q, clr_d;
    logic [ADDR_W-1:0] clra_addr_q, clra_addr_d;

    // Clear-pass outputs, one zero write per cycle.
    always_comb begin
        clr_d = (state_d == S_CLR);
        if (clr_d) begin
            clra_addr_d = cnt_d[ADDR_W-1:0];
        end else begin
            clra_addr_d = '0;
        end
    end

    // Clear-pass output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_q       <= 1'b0;
            clra_addr_q <= '0;
        end else begin
            clr_q       <= clr_d;
            clra_addr_q <= clra_addr_d;
        end
    end

    assign clra_mem  = clr_q;
    assign clra_wren = clr_q;
    assign clra_addr = clra_addr_q;
`else
    assign clra_mem  = 1'b0;
    assign clra_wren = 1'b0;
    assign clra_addr = '0;
`endif

endmodule

// File: tb/tb_iddmm_final_sub.sv
// Scoreboard bench for iddmm_final_sub (K=8, N=4) with a one-cycle-latency A/M memory model.
module tb_iddmm_final_sub;

    localparam int K  = 8;
    localparam int N  = 4;
    localparam int AW = 2;
`ifdef IDDMM_SUB_CLEAR_EN
    localparam int END_CYC = 3 * N + 3;
    localparam int EXP_CLR = N;
`else
    localparam int END_CYC = 2 * N + 3;
    localparam int EXP_CLR = 0;
`endif

    typedef struct packed {
        logic [K-1:0] data;
        int           cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          task_req;
    logic          task_end;
    logic [K-1:0]  res;
    logic          res_val;
    logic          clra_mem;
    logic          clra_wren;
    logic [AW-1:0] clra_addr;
    logic [K-1:0]  aj;
    logic [K-1:0]  an;
    logic [K-1:0]  mj;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_m;

    logic [K-1:0]  amem [N];
    logic [K-1:0]  mmem [N];
    exp_t          exp_q [$];

    int            cyc;
    int            t0;
    int            rel;
    int            n_tests;
    int            n_fail;
    int            end_cnt;
    int            rv_cnt;
    int            clr_seen;
    int            exp_end_cnt;
    int            exp_rv_cnt;
    bit            end_armed;
    bit            chk_zero;
    bit            chk_hold;
    bit            chk_cnt;
    bit            timeout_flag;
    logic [K-1:0]  hold_exp;
    exp_t          e;

    iddmm_final_sub #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .task_req  (task_req),
        .task_end  (task_end),
        .res       (res),
        .res_val   (res_val),
        .clra_mem  (clra_mem),
        .clra_wren (clra_wren),
        .clra_addr (clra_addr),
        .aj        (aj),
        .an        (an),
        .mj        (mj),
        .addr_a    (addr_a),
        .addr_m    (addr_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        aj  <= amem[addr_a];
        mj  <= mmem[addr_m];
    end

    // Monitor: every comparison lives here, sampled on the falling edge.
    initial begin : monitor
        n_tests  = 0;
        n_fail   = 0;
        end_cnt  = 0;
        rv_cnt   = 0;
        clr_seen = 0;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (chk_zero) begin
                n_tests++;
                if (res_val || task_end || clra_mem || clra_wren || clra_addr != 2'd0 ||
                    addr_a != 2'd0 || addr_m != 2'd0 || res != 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_outputs: got rv=%0b te=%0b cm=%0b cw=%0b ca=%0d aa=%0d am=%0d res=%h, expected all 0",
                             res_val, task_end, clra_mem, clra_wren, clra_addr, addr_a, addr_m, res);
                end
            end
            if (chk_hold) begin
                n_tests++;
                if (res !== hold_exp || res_val) begin
                    n_fail++;
                    $display("FAIL res_hold: got res=%h rv=%0b, expected res=%h rv=0", res, res_val, hold_exp);
                end
            end
            if (res_val) begin
                n_tests++;
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL res_unexpected: got res=%h at cycle %0d, expected no output", res, rel);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e.data || rel != e.cyc) begin
                        n_fail++;
                        $display("FAIL res_word: got %h at cycle %0d, expected %h at cycle %0d",
                                 res, rel, e.data, e.cyc);
                    end
                end
            end
            if (addr_a != addr_m) begin
                n_tests++;
                n_fail++;
                $display("FAIL addr_match: got addr_a=%0d addr_m=%0d, expected equal", addr_a, addr_m);
            end
            if (clra_wren || clra_mem) begin
                n_tests++;
                clr_seen++;
`ifdef IDDMM_SUB_CLEAR_EN
                if (!(clra_wren && clra_mem) || rel < 2 * N + 3 || rel > 3 * N + 2 ||
                    int'(clra_addr) != rel - (2 * N + 3)) begin
                    n_fail++;
                    $display("FAIL clear_pass: got cm=%0b cw=%0b addr=%0d at cycle %0d, expected addr %0d in cycles %0d..%0d",
                             clra_mem, clra_wren, clra_addr, rel, rel - (2 * N + 3), 2 * N + 3, 3 * N + 2);
                end
`else
                n_fail++;
                $display("FAIL clear_pass: got cm=%0b cw=%0b, expected 0 without clear feature", clra_mem, clra_wren);
`endif
            end
            if (task_end) begin
                n_tests++;
                end_cnt++;
                if (!end_armed || rel != END_CYC || exp_q.size() != 0 || clr_seen != EXP_CLR) begin
                    n_fail++;
                    $display("FAIL task_end: got armed=%0b cycle=%0d left=%0d clears=%0d, expected armed=1 cycle=%0d left=0 clears=%0d",
                             end_armed, rel, exp_q.size(), clr_seen, END_CYC, EXP_CLR);
                end
                clr_seen = 0;
            end
            if (chk_cnt) begin
                n_tests++;
                if (end_cnt != exp_end_cnt || rv_cnt != exp_rv_cnt) begin
                    n_fail++;
                    $display("FAIL burst_count: got ends=%0d words=%0d, expected ends=%0d words=%0d",
                             end_cnt, rv_cnt, exp_end_cnt, exp_rv_cnt);
                end
            end
            if (timeout_flag) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: got no task_end within budget, expected task_end at cycle %0d", END_CYC);
            end
        end
    end

    task automatic load(input logic [31:0] a_w, input logic [31:0] m_w);
        for (int j = 0; j < N; j++) begin
            amem[j] = a_w[8*j +: 8];
            mmem[j] = m_w[8*j +: 8];
        end
    endtask

    // Operand packing is word3..word0 (low word in the low byte).
    task automatic run(input logic [31:0] a_w, input logic [31:0] m_w, input logic [7:0] an_v,
                       input logic [7:0] an_late, input logic [31:0] exp_w, input bit hold);
        int e0;
        load(a_w, m_w);
        an = an_v;
        for (int j = 0; j < N; j++) begin
            exp_q.push_back('{data: exp_w[8*j +: 8], cyc: N + 3 + j});
        end
        e0        = end_cnt;
        end_armed = 1'b1;
        t0        = cyc;
        task_req  = 1'b1;
        for (int i = 0; i < 200 && end_cnt == e0; i++) begin
            @(posedge clk);
            #1;
            if (cyc - t0 == N + 2) an = an_late;
        end
        if (end_cnt == e0) begin
            timeout_flag = 1'b1;
            @(posedge clk);
            #1;
            timeout_flag = 1'b0;
            exp_q.delete();
        end
        end_armed = 1'b0;
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
            end
        end
        task_req = 1'b0;
        hold_exp = exp_w[31:24];
        chk_hold = 1'b1;
        @(posedge clk);
        #1;
        chk_hold = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        rst_n        = 1'b0;
        task_req     = 1'b0;
        an           = 8'h00;
        t0           = 0;
        end_armed    = 1'b0;
        chk_zero     = 1'b0;
        chk_hold     = 1'b0;
        chk_cnt      = 1'b0;
        timeout_flag = 1'b0;
        hold_exp     = 8'h00;
        exp_end_cnt  = 0;
        exp_rv_cnt   = 0;
        load(32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero = 1'b1;
        @(posedge clk);
        #1;
        chk_zero = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        run(32'h01020305, 32'h01020304, 8'h00, 8'h00, 32'h00000001, 1'b0);
        run(32'h01020303, 32'h01020304, 8'h00, 8'h01, 32'h01020303, 1'b0);
        run(32'h00000000, 32'h00000001, 8'h01, 8'h01, 32'hFFFFFFFF, 1'b0);
        run(32'h55AA55AA, 32'h55AA55AA, 8'h00, 8'h00, 32'h00000000, 1'b1);
        exp_end_cnt = 4;
        exp_rv_cnt  = 4 * N;
        chk_cnt     = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt = 1'b0;
        run(32'h55AA55AA, 32'h55AA55AA, 8'h00, 8'h00, 32'h00000000, 1'b0);
        run(32'h40302010, 32'h40301020, 8'h02, 8'h00, 32'h00000FF0, 1'b0);

        // Abort a run with reset in cycle 6, before any word is emitted.
        load(32'h01020305, 32'h01020304);
        an        = 8'h00;
        end_armed = 1'b0;
        t0        = cyc;
        task_req  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        task_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        chk_zero = 1'b1;
        @(posedge clk);
        #1;
        chk_zero = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        exp_end_cnt = 6;
        exp_rv_cnt  = 6 * N;
        chk_cnt     = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt = 1'b0;

        run(32'h01020305, 32'h01020304, 8'h00, 8'h00, 32'h00000001, 1'b0);
        exp_end_cnt = 7;
        exp_rv_cnt  = 7 * N;
        chk_cnt     = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
